// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative MUL.
// Define ALU_DIV_EN to add an iterative unsigned restoring divider as op 10.
module alu_multicycle #(
    parameter int         WIDTH      = 8,
    parameter logic [7:0] SREG_RESET = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 ready,
    input  logic [3:0]           op,
    input  logic                 use_carry,
    input  logic [WIDTH-1:0]     arg1,
    input  logic [WIDTH-1:0]     arg2,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Q,
    input  logic                 sreg_we,
    input  logic [7:0]           sreg_wdata,
    output logic [7:0]           sreg
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_LSL = 4'd3,
                           OP_LSR = 4'd4, OP_AND = 4'd5, OP_OR  = 4'd6, OP_XOR = 4'd7,
                           OP_CMP = 4'd8, OP_ASR = 4'd9, OP_DIV = 4'd10;

    typedef enum logic [1:0] {IDLE, ITER, PEND} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] wa, wb;
    logic [WIDTH-1:0]   wc;
    logic [3:0]         p_op;
    logic               p_uc, p_cin;
    logic [WIDTH-1:0]   p_a, p_b;

    logic accept, iter_op, exec_single, iter_fin;

    assign ready       = (state == IDLE) || (state == ITER && cnt == '0);
    assign accept      = start & ready;
    assign iter_fin    = (state == ITER) && (cnt == '0);
    assign exec_single = (state == PEND) || (state == IDLE && accept && !iter_op);

    always_comb begin
        iter_op = (op == OP_MUL);
`ifdef ALU_DIV_EN
        if (op == OP_DIV) iter_op = 1'b1;
`endif
    end

    // Single-cycle unit; a single op accepted while an iterative op completes runs from PEND.
    logic [3:0]       s_op;
    logic             s_uc, s_cin, ci, cb, s_legal, s_wq;
    logic [WIDTH-1:0] s_a, s_b, s_res;
    logic [WIDTH:0]   ax, bx, ext;
    logic             f_c, f_h, f_v, f_n, f_z;
    logic [7:0]       s_fl;

    always_comb begin
        s_op    = (state == PEND) ? p_op  : op;
        s_uc    = (state == PEND) ? p_uc  : use_carry;
        s_cin   = (state == PEND) ? p_cin : sreg[0];
        s_a     = (state == PEND) ? p_a   : arg1;
        s_b     = (state == PEND) ? p_b   : arg2;
        ci      = s_uc & s_cin;
        cb      = ci & (s_op == OP_SUB);
        ax      = {1'b0, s_a};
        bx      = {1'b0, s_b};
        ext     = '0;
        s_res   = '0;
        s_legal = 1'b1;
        s_wq    = 1'b1;
        f_c     = sreg[0];
        f_h     = sreg[5];
        f_v     = sreg[3];
        case (s_op)
            OP_ADD: begin
                ext   = ax + bx + (WIDTH+1)'(ci);
                s_res = ext[WIDTH-1:0];
                f_c   = ext[WIDTH];
                f_h   = ax[4] ^ bx[4] ^ ext[4];
                f_v   = (s_a[WIDTH-1] == s_b[WIDTH-1]) && (s_res[WIDTH-1] != s_a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                ext   = ax - bx - (WIDTH+1)'(cb);
                s_res = ext[WIDTH-1:0];
                f_c   = ext[WIDTH];
                f_h   = ax[4] ^ bx[4] ^ ext[4];
                f_v   = (s_a[WIDTH-1] != s_b[WIDTH-1]) && (s_res[WIDTH-1] != s_a[WIDTH-1]);
                s_wq  = (s_op != OP_CMP);
            end
            OP_LSL: begin
                s_res = {s_a[WIDTH-2:0], ci};
                f_c   = s_a[WIDTH-1];
                f_h   = s_a[3];
                f_v   = s_res[WIDTH-1] ^ f_c;
            end
            OP_LSR: begin
                s_res = {ci, s_a[WIDTH-1:1]};
                f_c   = s_a[0];
                f_v   = s_res[WIDTH-1] ^ f_c;
            end
            OP_ASR: begin
                s_res = {s_a[WIDTH-1], s_a[WIDTH-1:1]};
                f_c   = s_a[0];
                f_v   = s_res[WIDTH-1] ^ f_c;
            end
            OP_AND: begin s_res = s_a & s_b; f_v = 1'b0; end
            OP_OR:  begin s_res = s_a | s_b; f_v = 1'b0; end
            OP_XOR: begin s_res = s_a ^ s_b; f_v = 1'b0; end
            default: begin s_legal = 1'b0; s_wq = 1'b0; end
        endcase
        f_n = s_res[WIDTH-1];
        f_z = (s_res == '0);
        if (s_op == OP_SUB && s_uc) f_z = sreg[1] & f_z;
        s_fl = {sreg[7:6], f_h, f_n ^ f_v, f_v, f_n, f_z, f_c};
    end

    // Iterative unit: shift-add multiply; wa=product, wb=shifted multiplicand, wc=multiplier.
    logic [2*WIDTH-1:0] mul_next, it_res, ld_wa;
    logic               it_c, it_z;

    assign mul_next = wa + (wc[0] ? wb : '0);

`ifdef ALU_DIV_EN
    // Divide reuses wa as {remainder, quotient-in-progress} and wc as the divisor.
    logic               it_div;
    logic [WIDTH:0]     rsh;
    logic [WIDTH-1:0]   rdiff;
    logic               ge;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        rsh      = {wa[2*WIDTH-1:WIDTH], wa[WIDTH-1]};
        ge       = (rsh >= {1'b0, wc});
        rdiff    = rsh[WIDTH-1:0] - wc;
        div_next = {ge ? rdiff : rsh[WIDTH-1:0], wa[WIDTH-2:0], ge};
        it_res   = it_div ? div_next : mul_next;
        it_c     = it_div ? (wc == '0) : mul_next[2*WIDTH-1];
        it_z     = it_div ? (div_next[WIDTH-1:0] == '0) : (mul_next == '0);
        ld_wa    = (op == OP_DIV) ? {{WIDTH{1'b0}}, arg1} : '0;
    end
`else
    always_comb begin
        it_res = mul_next;
        it_c   = mul_next[2*WIDTH-1];
        it_z   = (mul_next == '0);
        ld_wa  = '0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            wa    <= '0;
            wb    <= '0;
            wc    <= '0;
            p_op  <= '0;
            p_uc  <= 1'b0;
            p_cin <= 1'b0;
            p_a   <= '0;
            p_b   <= '0;
            Q     <= '0;
            done  <= 1'b0;
            sreg  <= SREG_RESET;
`ifdef ALU_DIV_EN
            it_div <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (exec_single) begin
                done <= 1'b1;
                if (s_wq) Q <= {{WIDTH{1'b0}}, s_res};
            end
            case (state)
                IDLE: ;
                PEND: state <= IDLE;
                ITER: begin
`ifdef ALU_DIV_EN
                    if (it_div) wa <= div_next;
                    else
`endif
                    begin
                        wa <= mul_next;
                        wb <= wb << 1;
                        wc <= wc >> 1;
                    end
                    cnt <= cnt - CW'(1);
                    if (iter_fin) begin
                        Q     <= it_res;
                        done  <= 1'b1;
                        state <= IDLE;
                        if (accept && !iter_op) begin
                            state <= PEND;
                            p_op  <= op;
                            p_uc  <= use_carry;
                            p_cin <= sreg[0];
                            p_a   <= arg1;
                            p_b   <= arg2;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (accept && iter_op) begin
                state <= ITER;
                cnt   <= CW'(WIDTH-1);
                wa    <= ld_wa;
                wb    <= {{WIDTH{1'b0}}, arg1};
                wc    <= arg2;
`ifdef ALU_DIV_EN
                it_div <= (op == OP_DIV);
`endif
            end
            if (sreg_we)                     sreg <= sreg_wdata;
            else if (exec_single && s_legal) sreg <= s_fl;
            else if (iter_fin)               sreg <= {sreg[7:2], it_z, it_c};
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=8): directed spec cases plus randomized ops
// against an arithmetic reference model; honours ALU_DIV_EN like the design.
module tb_alu_multicycle;
    logic        clk = 1'b0;
    logic        reset, start, ready, use_carry, done, sreg_we;
    logic [3:0]  op;
    logic [7:0]  arg1, arg2, sreg_wdata, sreg;
    logic [15:0] Q;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(8), .SREG_RESET(8'h00)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready), .op(op),
        .use_carry(use_carry), .arg1(arg1), .arg2(arg2), .done(done), .Q(Q),
        .sreg_we(sreg_we), .sreg_wdata(sreg_wdata), .sreg(sreg)
    );

    typedef struct { logic [15:0] q; logic [7:0] s; } exp_t;
    exp_t        exp_q[$];
    int          checks = 0, failures = 0;
    logic [15:0] m_q = '0;
    logic [7:0]  m_sreg = '0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic bit is_iter(input logic [3:0] o);
`ifdef ALU_DIV_EN
        return (o == 4'd2) || (o == 4'd10);
`else
        return (o == 4'd2);
`endif
    endfunction

    // Reference model: plain integer arithmetic on the architectural state (Q, SREG).
    function automatic void model(input logic [3:0] o, input bit uc, input logic [7:0] a8, input logic [7:0] b8);
        int a = int'(a8), b = int'(b8), cin, full, r, sv;
        bit c, h, v, n, z;
        exp_t e;
        cin = uc ? int'(m_sreg[0]) : 0;
        c = m_sreg[0]; h = m_sreg[5]; v = m_sreg[3];
        r = 0;
        case (o)
            4'd0: begin
                full = a + b + cin; r = full % 256; c = full > 255;
                h = (a % 16 + b % 16 + cin) > 15;
                sv = sgn(a) + sgn(b) + cin; v = (sv > 127) || (sv < -128);
            end
            4'd1, 4'd8: begin
                if (o == 4'd8) cin = 0;
                full = a - b - cin; r = (full + 256) % 256; c = full < 0;
                h = (a % 16) - (b % 16) - cin < 0;
                sv = sgn(a) - sgn(b) - cin; v = (sv > 127) || (sv < -128);
            end
            4'd3: begin r = (a * 2 + cin) % 256; c = a >= 128; h = (a / 8) % 2 == 1; end
            4'd4: begin r = a / 2 + cin * 128; c = a % 2 == 1; end
            4'd9: begin r = a / 2 + ((a >= 128) ? 128 : 0); c = a % 2 == 1; end
            4'd5: begin r = a & b; v = 0; end
            4'd6: begin r = a | b; v = 0; end
            4'd7: begin r = a ^ b; v = 0; end
            default: ;
        endcase
        case (o)
            4'd0, 4'd1, 4'd8, 4'd3, 4'd4, 4'd9, 4'd5, 4'd6, 4'd7: begin
                n = r >= 128;
                z = (r == 0);
                if (o == 4'd1 && uc) z = z && m_sreg[1];
                if (o == 4'd3 || o == 4'd4 || o == 4'd9) v = n ^ c;
                m_sreg[5:0] = {h, n ^ v, v, n, z, c};
                if (o != 4'd8) m_q = 16'(r);
            end
            4'd2: begin
                full = a * b; m_q = 16'(full);
                m_sreg[0] = full >= 32768; m_sreg[1] = (full == 0);
            end
`ifdef ALU_DIV_EN
            4'd10: begin
                if (b == 0) begin m_q = {a8, 8'hFF}; m_sreg[0] = 1; m_sreg[1] = 0; end
                else begin
                    m_q = 16'((a % b) * 256 + a / b);
                    m_sreg[0] = 0; m_sreg[1] = (a / b == 0);
                end
            end
`endif
            default: ;
        endcase
        e.q = m_q; e.s = m_sreg;
        exp_q.push_back(e);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_done: got done=1 expected no completion at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_Q", Q, e.q);
                    chk("sb_sreg", {8'h00, sreg}, {8'h00, e.s});
                end
            end
        end
    end

    task automatic issue(input logic [3:0] o, input bit uc, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        op = o; use_carry = uc; arg1 = a; arg2 = b; start = 1'b1;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        if (!ready) begin
            checks++; failures++;
            $display("FAIL issue_timeout: got ready=0 expected ready=1 within 50 cycles");
            start = 1'b0;
            return;
        end
        @(posedge clk);
        model(o, uc, a, b);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        start = 1'b0;
        while ((exp_q.size() != 0 || !ready) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic write_sreg(input logic [7:0] v);
        @(negedge clk);
        start = 1'b0; sreg_we = 1'b1; sreg_wdata = v;
        @(negedge clk);
        sreg_we = 1'b0; m_sreg = v;
        chk("sreg_write", {8'h00, sreg}, {8'h00, v});
    endtask

    initial begin
        int  ready_low, done_at, gap;
        bit  prev_iter;
        logic [3:0] o;
        bit uc;
        reset = 1'b1; start = 1'b0; op = '0; use_carry = 1'b0; arg1 = '0; arg2 = '0;
        sreg_we = 1'b0; sreg_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_Q", Q, 16'h0000);
        chk("rst_sreg", {8'h00, sreg}, 16'h0000);
        chk("rst_ready", {15'd0, ready}, 16'd1);
        chk("rst_done", {15'd0, done}, 16'd0);
        reset = 1'b0;

        issue(4'd0, 0, 8'h7F, 8'h01); drain();
        chk("add_Q", Q, 16'h0080);
        chk("add_sreg", {8'h00, sreg}, 16'h002C);

        write_sreg(8'h03);
        issue(4'd1, 1, 8'h10, 8'h0F); drain();
        chk("sbc_Q", Q, 16'h0000);
        chk("sbc_sreg", {8'h00, sreg}, 16'h0022);

        // MUL latency, busy window, and a start during busy that must be ignored
        issue(4'd2, 0, 8'hFF, 8'hFF);
        ready_low = 0; done_at = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 3) begin op = 4'd0; arg1 = 8'h01; arg2 = 8'h01; start = 1'b1; end
            if (n == 4) start = 1'b0;
            if (!ready) ready_low++;
            if (done && done_at == 0) done_at = n;
        end
        chk("mul_ready_low", 16'(ready_low), 16'd7);
        chk("mul_done_cycle", 16'(done_at), 16'd9);
        chk("mul_Q", Q, 16'hFE01);
        chk("mul_C", {15'd0, sreg[0]}, 16'd1);
        chk("mul_Z", {15'd0, sreg[1]}, 16'd0);
        drain();

        write_sreg(8'h01);
        issue(4'd3, 1, 8'h80, 8'h00); drain();
        chk("rol_Q", Q, 16'h0001);
        chk("rol_flags", {12'd0, sreg[4:1]}, 16'b1100);
        chk("rol_C", {15'd0, sreg[0]}, 16'd1);
        issue(4'd9, 0, 8'h81, 8'h00); drain();
        chk("asr_Q", Q, 16'h00C0);
        chk("asr_C", {15'd0, sreg[0]}, 16'd1);

        // sreg write on the MUL completion edge overrides the MUL flags
        issue(4'd2, 0, 8'hFF, 8'hFF);
        exp_q[exp_q.size()-1].s = 8'h80;
        m_sreg = 8'h80;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 8) begin sreg_we = 1'b1; sreg_wdata = 8'h80; end
            if (n == 9) sreg_we = 1'b0;
        end
        chk("we_on_done_sreg", {8'h00, sreg}, 16'h0080);
        drain();

        // Reset in the middle of a MUL: no completion, everything back to reset values
        issue(4'd2, 0, 8'h12, 8'h34);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; exp_q.delete(); m_q = '0; m_sreg = 8'h00;
        #1;
        chk("midrst_Q", Q, 16'h0000);
        chk("midrst_sreg", {8'h00, sreg}, 16'h0000);
        chk("midrst_ready", {15'd0, ready}, 16'd1);
        @(negedge clk); reset = 1'b0;
        repeat (12) @(negedge clk);
        issue(4'd0, 0, 8'h12, 8'h34); drain();
        chk("post_rst_add", Q, 16'h0046);

`ifdef ALU_DIV_EN
        issue(4'd10, 0, 8'h64, 8'h07); drain();
        chk("div_Q", Q, 16'h020E);
        issue(4'd10, 0, 8'h5A, 8'h00); drain();
        chk("div0_Q", Q, 16'h5AFF);
        chk("div0_C", {15'd0, sreg[0]}, 16'd1);
`else
        issue(4'd10, 0, 8'h64, 8'h07); drain();
        chk("op10_illegal_Q", Q, 16'h0046);
`endif

        // Random ops, including back-to-back issue out of an iterative completion cycle
        prev_iter = 0; gap = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                drain();
                write_sreg(8'($urandom));
                gap = 1;
            end
            o  = 4'($urandom_range(0, 15));
            uc = 1'($urandom_range(0, 1));
            if (prev_iter && gap == 0) uc = 0;
            issue(o, uc, 8'($urandom), 8'($urandom));
            prev_iter = is_iter(o);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                @(negedge clk); start = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
